// File: rtl/line_bus2_master.sv
// Cache-line master for bus2: bursts a line out on write, or issues a read command and collects the beats.
// Define LINE_BUS2_MASTER_TIMEOUT_EN to give up on a missing RESPONSE after TIMEOUT_CYCLES and flag err.
module line_bus2_master #(
    parameter int ADDR2_BUS_SIZE  = 15,
    parameter int DATA2_BUS_SIZE  = 16,
    parameter int CTR2_BUS_SIZE   = 2,
    parameter int CACHE_LINE_SIZE = 16,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR2_BUS_SIZE-1:0]    req_addr,
    input  logic [CACHE_LINE_SIZE*8-1:0] req_wdata,
    output logic                         done,
    output logic                         err,
    output logic [CACHE_LINE_SIZE*8-1:0] rdata,
    output logic [ADDR2_BUS_SIZE-1:0]    a2_out,
    output logic                         a2_oe,
    output logic [DATA2_BUS_SIZE-1:0]    d2_out,
    output logic                         d2_oe,
    output logic [CTR2_BUS_SIZE-1:0]     c2_out,
    output logic                         c2_oe,
    input  logic [DATA2_BUS_SIZE-1:0]    d2_in,
    input  logic [CTR2_BUS_SIZE-1:0]     c2_in
);

    localparam int LINE_BITS = CACHE_LINE_SIZE * 8;
    localparam int BEATS     = LINE_BITS / DATA2_BUS_SIZE;
    localparam int BW        = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [CTR2_BUS_SIZE-1:0] C2_NOP        = CTR2_BUS_SIZE'(0);
    localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = CTR2_BUS_SIZE'(1);
    localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = CTR2_BUS_SIZE'(2);
    localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = CTR2_BUS_SIZE'(3);

    typedef enum logic [2:0] {
        IDLE,
        WR_BURST,
        RD_CMD,
        WAIT_RESP,
        RD_BURST,
        DONE
    } state_t;

    state_t                 state;
    logic [LINE_BITS-1:0]   shift_q;
    logic                   write_q;
    logic [BW-1:0]          beat;

`ifdef LINE_BUS2_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcount;
    logic          err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Outputs are registered: each transition loads the values the next state presents on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_q   <= '0;
            write_q   <= 1'b0;
            beat      <= '0;
            req_ready <= 1'b1;
            done      <= 1'b0;
            rdata     <= '0;
            a2_out    <= '0;
            a2_oe     <= 1'b0;
            d2_out    <= '0;
            d2_oe     <= 1'b0;
            c2_out    <= C2_NOP;
            c2_oe     <= 1'b0;
`ifdef LINE_BUS2_MASTER_TIMEOUT_EN
            tcount    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        write_q   <= req_write;
                        beat      <= '0;
                        a2_out    <= req_addr;
                        a2_oe     <= 1'b1;
                        c2_oe     <= 1'b1;
                        if (req_write) begin
                            state   <= WR_BURST;
                            c2_out  <= C2_WRITE_LINE;
                            d2_out  <= req_wdata[DATA2_BUS_SIZE-1:0];
                            d2_oe   <= 1'b1;
                            shift_q <= req_wdata >> DATA2_BUS_SIZE;
                        end else begin
                            state  <= RD_CMD;
                            c2_out <= C2_READ_LINE;
                        end
                    end
                end

                WR_BURST: begin
                    if (beat == BW'(BEATS - 1)) begin
                        state  <= WAIT_RESP;
                        beat   <= '0;
                        a2_out <= '0;
                        a2_oe  <= 1'b0;
                        d2_out <= '0;
                        d2_oe  <= 1'b0;
                        c2_out <= C2_NOP;
                        c2_oe  <= 1'b0;
                    end else begin
                        beat    <= beat + 1'b1;
                        d2_out  <= shift_q[DATA2_BUS_SIZE-1:0];
                        shift_q <= shift_q >> DATA2_BUS_SIZE;
                    end
                end

                RD_CMD: begin
                    state  <= WAIT_RESP;
                    a2_out <= '0;
                    a2_oe  <= 1'b0;
                    c2_out <= C2_NOP;
                    c2_oe  <= 1'b0;
                end

                // Read lines shift in from the top so beat 0 ends up in the low bits.
                WAIT_RESP: begin
                    if (c2_in == C2_RESPONSE) begin
`ifdef LINE_BUS2_MASTER_TIMEOUT_EN
                        tcount <= '0;
`endif
                        if (write_q) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            rdata <= {d2_in, rdata[LINE_BITS-1:DATA2_BUS_SIZE]};
                            beat  <= BW'(1);
                            state <= RD_BURST;
                        end
                    end
`ifdef LINE_BUS2_MASTER_TIMEOUT_EN
                    else if (tcount == TW'(TIMEOUT_CYCLES - 1)) begin
                        tcount <= '0;
                        state  <= DONE;
                        done   <= 1'b1;
                        err_q  <= 1'b1;
                    end else begin
                        tcount <= tcount + 1'b1;
                    end
`endif
                end

                RD_BURST: begin
                    rdata <= {d2_in, rdata[LINE_BITS-1:DATA2_BUS_SIZE]};
                    if (beat == BW'(BEATS - 1)) begin
                        beat  <= '0;
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end

                DONE: begin
                    done      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
`ifdef LINE_BUS2_MASTER_TIMEOUT_EN
                    err_q     <= 1'b0;
`endif
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_bus2_master.sv
// Scoreboard bench for line_bus2_master: stimulus pushes expected bus beats and done results,
// a negedge monitor pops and compares them whenever the master drives the bus or pulses done.
module tb_line_bus2_master;

    localparam logic [1:0] C2_NOP        = 2'd0;
    localparam logic [1:0] C2_RESPONSE   = 2'd1;
    localparam logic [1:0] C2_READ_LINE  = 2'd2;
    localparam logic [1:0] C2_WRITE_LINE = 2'd3;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [14:0]  req_addr;
    logic [127:0] req_wdata;
    logic         done;
    logic         err;
    logic [127:0] rdata;
    logic [14:0]  a2_out;
    logic         a2_oe;
    logic [15:0]  d2_out;
    logic         d2_oe;
    logic [1:0]   c2_out;
    logic         c2_oe;
    logic [15:0]  d2_in;
    logic [1:0]   c2_in;

    typedef struct {
        logic [1:0]  c2;
        logic [14:0] a2;
        logic [15:0] d2;
        logic        d2_oe;
    } bus_item_t;

    typedef struct {
        logic         err;
        logic         chk_rdata;
        logic [127:0] rdata;
    } done_item_t;

    bus_item_t  bus_q[$];
    done_item_t done_q[$];
    bus_item_t  mon_b;
    done_item_t mon_d;

    int checks = 0;
    int passes = 0;

    line_bus2_master #(
        .ADDR2_BUS_SIZE (15),
        .DATA2_BUS_SIZE (16),
        .CTR2_BUS_SIZE  (2),
        .CACHE_LINE_SIZE(16),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .a2_out   (a2_out),
        .a2_oe    (a2_oe),
        .d2_out   (d2_out),
        .d2_oe    (d2_oe),
        .c2_out   (c2_out),
        .c2_oe    (c2_oe),
        .d2_in    (d2_in),
        .c2_in    (c2_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp)
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
        else
            passes++;
    endtask

    task automatic push_bus(input logic [1:0] c2, input logic [14:0] a2, input logic [15:0] d2, input logic oe);
        bus_item_t b;
        b.c2 = c2; b.a2 = a2; b.d2 = d2; b.d2_oe = oe;
        bus_q.push_back(b);
    endtask

    task automatic push_done(input logic e, input logic chk, input logic [127:0] rd);
        done_item_t d;
        d.err = e; d.chk_rdata = chk; d.rdata = rd;
        done_q.push_back(d);
    endtask

    task automatic wait_done(input int limit, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (done !== 1'b1 && cycles < limit);
    endtask

    // Monitor: every cycle the master drives bus2 or pulses done must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (a2_oe === 1'b1 || d2_oe === 1'b1 || c2_oe === 1'b1) begin
                if (bus_q.size() == 0) begin
                    check_value("bus_unexpected_drive", 128'(c2_out), 128'hx);
                end else begin
                    mon_b = bus_q.pop_front();
                    check_value("bus_a2_oe", 128'(a2_oe), 128'(1'b1));
                    check_value("bus_c2_oe", 128'(c2_oe), 128'(1'b1));
                    check_value("bus_d2_oe", 128'(d2_oe), 128'(mon_b.d2_oe));
                    check_value("bus_c2_out", 128'(c2_out), 128'(mon_b.c2));
                    check_value("bus_a2_out", 128'(a2_out), 128'(mon_b.a2));
                    if (mon_b.d2_oe)
                        check_value("bus_d2_out", 128'(d2_out), 128'(mon_b.d2));
                end
            end
            if (done === 1'b1) begin
                if (done_q.size() == 0) begin
                    check_value("done_unexpected", 128'(done), 128'(1'b0));
                end else begin
                    mon_d = done_q.pop_front();
                    check_value("done_err", 128'(err), 128'(mon_d.err));
                    if (mon_d.chk_rdata)
                        check_value("done_rdata", rdata, mon_d.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] line_a;
        logic [127:0] line_b;
        logic [127:0] exp_rd;
        logic [15:0]  rd_beat [8];
        int           cyc;

        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        d2_in     = '0;
        c2_in     = C2_NOP;
        rst_n     = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_value("reset_req_ready", 128'(req_ready), 128'(1'b1));
        check_value("reset_done", 128'(done), 128'(1'b0));
        check_value("reset_err", 128'(err), 128'(1'b0));
        check_value("reset_oe", 128'({a2_oe, d2_oe, c2_oe}), 128'(3'b000));
        check_value("reset_bus_out", 128'({a2_out, d2_out, c2_out}), 128'(0));
        check_value("reset_rdata", rdata, 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Write 0x1234 with bytes 0x00..0x0F, RESPONSE three wait cycles after the burst.
        @(negedge clk);
        for (int k = 0; k < 16; k++) line_a[k*8 +: 8] = 8'(k);
        for (int k = 0; k < 8; k++) push_bus(C2_WRITE_LINE, 15'h1234, {8'(2*k+1), 8'(2*k)}, 1'b1);
        push_done(1'b0, 1'b0, '0);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 15'h1234;
        req_wdata = line_a;
        @(negedge clk);
        check_value("wr_accept_ready_low", 128'(req_ready), 128'(1'b0));
        req_valid = 1'b0;
        repeat (11) @(negedge clk);
        c2_in = C2_RESPONSE;
        wait_done(6, cyc);
        check_value("wr_done_latency", 128'(cyc), 128'(1));
        check_value("wr_done_ready_low", 128'(req_ready), 128'(1'b0));
        c2_in = C2_NOP;
        @(negedge clk);
        check_value("wr_done_one_cycle", 128'(done), 128'(1'b0));
        check_value("wr_idle_ready", 128'(req_ready), 128'(1'b1));

        // Read 0x0042 with req_valid held; the held request becomes a write once back in IDLE.
        for (int k = 0; k < 8; k++) begin
            rd_beat[k] = 16'hBBAA + 16'(k) * 16'h1111;
            exp_rd[k*16 +: 16] = rd_beat[k];
        end
        for (int k = 0; k < 16; k++) line_b[k*8 +: 8] = 8'hA0 + 8'(k);
        push_bus(C2_READ_LINE, 15'h0042, 16'h0000, 1'b0);
        for (int k = 0; k < 8; k++) push_bus(C2_WRITE_LINE, 15'h0555, {8'hA0 + 8'(2*k+1), 8'hA0 + 8'(2*k)}, 1'b1);
        push_done(1'b0, 1'b1, exp_rd);
        push_done(1'b0, 1'b0, '0);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 15'h0042;
        @(negedge clk);
        req_write = 1'b1;
        req_addr  = 15'h0555;
        req_wdata = line_b;
        @(negedge clk);
        c2_in = C2_READ_LINE;
        @(negedge clk);
        c2_in = C2_WRITE_LINE;
        @(negedge clk);
        c2_in = C2_RESPONSE;
        d2_in = rd_beat[0];
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            d2_in = rd_beat[k];
            c2_in = k[0] ? C2_RESPONSE : C2_NOP;
            if (k == 4) check_value("rd_busy_ready_low", 128'(req_ready), 128'(1'b0));
        end
        wait_done(6, cyc);
        check_value("rd_done_latency", 128'(cyc), 128'(1));
        c2_in = C2_NOP;
        d2_in = '0;
        @(negedge clk);
        check_value("rd_idle_ready", 128'(req_ready), 128'(1'b1));
        check_value("rd_rdata_hold", rdata, exp_rd);
        check_value("rd_rdata_low_beat", 128'(rdata[15:0]), 128'(16'hBBAA));
        @(negedge clk);
        check_value("b2b_accept_ready_low", 128'(req_ready), 128'(1'b0));
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        c2_in = C2_RESPONSE;
        wait_done(6, cyc);
        check_value("b2b_done_latency", 128'(cyc), 128'(1));
        c2_in = C2_NOP;

        // Reset while beat 4 of a write is on the bus.
        @(negedge clk);
        for (int k = 0; k < 5; k++) push_bus(C2_WRITE_LINE, 15'h0AAA, {8'hC0 + 8'(2*k+1), 8'hC0 + 8'(2*k)}, 1'b1);
        for (int k = 0; k < 16; k++) req_wdata[k*8 +: 8] = 8'hC0 + 8'(k);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 15'h0AAA;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_value("abort_oe_released", 128'({a2_oe, d2_oe, c2_oe}), 128'(3'b000));
        check_value("abort_req_ready", 128'(req_ready), 128'(1'b1));
        check_value("abort_no_done", 128'(done), 128'(1'b0));
        check_value("abort_rdata_cleared", rdata, 128'(0));
        repeat (3) @(negedge clk);

        // Release reset with a read already requested; nobody answers it.
        rst_n     = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 15'h0123;
        push_bus(C2_READ_LINE, 15'h0123, 16'h0000, 1'b0);
`ifdef LINE_BUS2_MASTER_TIMEOUT_EN
        push_done(1'b1, 1'b1, 128'(0));
`endif
        @(negedge clk);
        check_value("post_reset_accept", 128'(req_ready), 128'(1'b0));
        req_valid = 1'b0;
`ifdef LINE_BUS2_MASTER_TIMEOUT_EN
        wait_done(20, cyc);
        check_value("timeout_latency", 128'(cyc), 128'(11));
        @(negedge clk);
        check_value("timeout_err_cleared", 128'(err), 128'(1'b0));
        check_value("timeout_idle_ready", 128'(req_ready), 128'(1'b1));
`else
        repeat (30) @(negedge clk);
        check_value("wait_forever_busy", 128'(req_ready), 128'(1'b0));
        check_value("wait_forever_no_done", 128'(done), 128'(1'b0));
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        repeat (3) @(negedge clk);
        check_value("bus_queue_drained", 128'(bus_q.size()), 128'(0));
        check_value("done_queue_drained", 128'(done_q.size()), 128'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
